pcm_to_i2s: RTL
===============

# pcm_to_i2s

Stereo PCM-to-I2S transmitter and bus master for the I2S path. It accepts left/right sample pairs over a valid/ready handshake into a one-entry holding register. It generates the word-select signal and shifts each word MSB-first, one bit-clock after the WS edge, in standard I2S format. It sits at the output of the beamformer datapath and is bit-compatible with the on-chip I2S receiver, so it can also drive loopback tests.

## Interface
- `NUMBER_OF_BITS`, default 8: PCM word width; taken from the shared parameters.
- `SLOT_BITS`, default 16: clk cycles per channel slot. Frame length = 2*SLOT_BITS. Must satisfy SLOT_BITS >= NUMBER_OF_BITS+1; elaboration error otherwise.
- `clk` input, 1: bit clock; all logic on posedge.
- `reset` input, 1: synchronous, active-high.
- `en` input, 1: transmit enable.
- `in_valid` input, 1: sample pair offered.
- `in_ready` output, 1: holding register empty.
- `in_left` input, NUMBER_OF_BITS: left sample, two's complement.
- `in_right` input, NUMBER_OF_BITS: right sample.
- `ws_out` output, 1: word select; 0 = left, 1 = right; registered.
- `sd_out` output, 1: serial data; registered.
- `underflow` output, 1: one-cycle pulse when a frame starts with no sample held.

## Operation
- Frame counter t runs 0..2*SLOT_BITS-1 while `en`=1 and wraps to 0.
  - Left slot: t < SLOT_BITS.
  - Right slot: t >= SLOT_BITS; slot position s = t - SLOT_BITS.
- `ws_out` = (t >= SLOT_BITS).
- `sd_out` by slot position s:
  - s = 0: `sd_out` = 0.
  - s = k, 1 <= k <= NUMBER_OF_BITS: `sd_out` = word bit [NUMBER_OF_BITS-k], i.e. MSB first.
  - s > NUMBER_OF_BITS: `sd_out` = 0.
- Holding register, one entry: left+right pair plus a full flag.
  - `in_ready` = !full.
  - Accept on a cycle with `in_valid` && `in_ready`; full is set on the next edge.
- Frame load occurs on the edge where t wraps 2*SLOT_BITS-1 -> 0:
  - If full: both shift words take the held pair and full clears.
  - If empty: both shift words load 0 and `underflow` pulses high for the cycle t=0.
- Accept and load on the same edge: the holding register was empty, so the frame loads zeros and flags underflow. The accepted pair lands in the holding register and is used at the next load.
- `en`=0:
  - t forced to 0; `ws_out`=0, `sd_out`=0; shift words cleared.
  - Holding register keeps its contents and the handshake stays live.
  - No `underflow` is generated.
- `en` 0->1: the first frame transmits zeros with no underflow flag, identical to the first frame after reset. Loading starts at the first wrap.
- Reset mid-frame: everything returns to reset values on the next edge, and any held pair is discarded.

## Timing
- Reset values: t=0, `ws_out`=0, `sd_out`=0, `underflow`=0, holding register empty, `in_ready`=1, shift words 0.
- `ws_out` and `sd_out` for cycle t are flop outputs valid for that whole cycle. The I2S receiver samples them on its own posedge with one cycle of skew absorbed by the slot-0 gap.
- Latency: a pair accepted before the edge entering t=2*SLOT_BITS-1 is loaded at the next wrap. Its left MSB appears at t=1 of that frame and its right MSB at t=SLOT_BITS+1.
- Throughput: one pair per 2*SLOT_BITS cycles. `in_ready` stays low from accept until the next load edge.
- `in_valid` may drop without acceptance; no data is latched then.

## Structure
- Shared parameters: NUMBER_OF_BITS, plus SLOT_BITS as a new shared constant so receiver, transmitter and top-level WS divider agree on frame length.
- Sub-module `i2s_tx_slot_counter`: frame counter with `en`/`reset`. It outputs t, the ws level, slot position s and the wrap/load pulse.
- Top of block: holding register, two shift words, output flops, underflow logic.

## Test plan
- Reset, `en`=1, no input → `ws_out` toggles every 16 cycles (32-cycle period); `sd_out` stays 0. `underflow` pulses at t=0 of the second and every later frame, never in the first.
- Present 8'hA5/8'h3C with `in_valid` before the first wrap → in frame 2, `sd_out` at t=1..8 = 1,0,1,0,0,1,0,1 and at t=17..24 = 0,0,1,1,1,1,0,0. All other cycles are 0, and there is no underflow.
- Stream back-to-back pairs with `in_valid` held high → one accept per 32 cycles, `in_ready` low between load edges, no underflow after the first load.
- Assert `in_valid` only in the wrap cycle with the holding register empty → that frame is zeros with `underflow`=1. The pair is transmitted in the following frame.
- Drop `en` mid-right-slot with a pair held → outputs go to 0 the next cycle and `in_ready` stays 0. After `en` rises, there is one zero frame, then the held pair is sent.
- Assert `reset` mid-frame with a pair held → all outputs take reset values next cycle, `in_ready`=1, and the held pair is never transmitted.

Source files
------------

// File: rtl/pcm_to_i2s_pkg.sv
// Shared constants for the I2S path: PCM word width and channel slot length,
// so receiver, transmitter and the top-level WS divider agree on the frame.
package pcm_to_i2s_pkg;

  localparam int NUMBER_OF_BITS = 8;
  localparam int SLOT_BITS      = 16;

  // Clock cycles in one stereo frame (left slot + right slot).
  function automatic int frame_cycles(input int slot_bits);
    return 2 * slot_bits;
  endfunction

endpackage

// File: rtl/i2s_tx_slot_counter.sv
// Frame position counter for the I2S transmitter. Presents the word-select
// level and slot position of the cycle that starts at the next edge, plus the
// wrap pulse marking the edge where a new frame begins and words are loaded.
module i2s_tx_slot_counter #(
  parameter int SLOT_BITS = pcm_to_i2s_pkg::SLOT_BITS,
  parameter int T_W       = $clog2(pcm_to_i2s_pkg::frame_cycles(SLOT_BITS))
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           ws_next,
  output logic [T_W-1:0] s_next,
  output logic           wrap
);

  localparam int             FRAME  = pcm_to_i2s_pkg::frame_cycles(SLOT_BITS);
  localparam logic [T_W-1:0] T_LAST = T_W'(FRAME - 1);
  localparam logic [T_W-1:0] T_SLOT = T_W'(SLOT_BITS);

  logic [T_W-1:0] t;
  logic [T_W-1:0] t_next;

  // The load edge only exists while transmitting; a disabled block never wraps.
  assign wrap = en && (t == T_LAST);

  // Next frame position: hold at 0 while disabled, wrap at end of frame.
  always_comb begin
    t_next = t + 1'b1;
    if (!en || wrap) begin
      t_next = '0;
    end
  end

  // Frame position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      t <= '0;
    end else begin
      t <= t_next;
    end
  end

  // Channel and in-slot position of the upcoming cycle.
  always_comb begin
    ws_next = (t_next >= T_SLOT);
    s_next  = ws_next ? (t_next - T_SLOT) : t_next;
  end

endmodule

// File: rtl/pcm_to_i2s.sv
// Stereo PCM to I2S transmitter. A one-entry holding register takes left/right
// pairs; at each frame boundary the held pair moves into two shift words that
// are sent MSB first, one bit clock after each WS edge.
//
// Handshake: a pair is accepted on any posedge where in_valid && in_ready;
// in_ready is high exactly when the holding register is empty, and in_valid
// may be withdrawn at any time without anything being latched.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = pcm_to_i2s_pkg::NUMBER_OF_BITS,
  parameter int SLOT_BITS      = pcm_to_i2s_pkg::SLOT_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  output logic                      ws_out,
  output logic                      sd_out,
  output logic                      underflow
);

  localparam int             T_W    = $clog2(pcm_to_i2s_pkg::frame_cycles(SLOT_BITS));
  localparam logic [T_W-1:0] S_LAST = T_W'(NUMBER_OF_BITS);

  // A slot must hold the one-cycle gap plus every data bit.
  if (SLOT_BITS < NUMBER_OF_BITS + 1) begin : g_bad_slot
    $error("pcm_to_i2s: SLOT_BITS must be at least NUMBER_OF_BITS+1");
  end

  logic                      ws_next;
  logic [T_W-1:0]            s_next;
  logic                      wrap;
  logic                      full;
  logic                      accept;
  logic [NUMBER_OF_BITS-1:0] hold_left;
  logic [NUMBER_OF_BITS-1:0] hold_right;
  logic [NUMBER_OF_BITS-1:0] left_word;
  logic [NUMBER_OF_BITS-1:0] right_word;
  logic                      data_slot;

  i2s_tx_slot_counter #(
    .SLOT_BITS (SLOT_BITS),
    .T_W       (T_W)
  ) u_slot_counter (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .ws_next (ws_next),
    .s_next  (s_next),
    .wrap    (wrap)
  );

  assign in_ready  = !full;
  assign accept    = in_valid && !full;
  assign data_slot = (s_next != '0) && (s_next <= S_LAST);

  // Holding register. On a load edge the held pair is consumed; a pair
  // accepted on that same edge found the register empty and stays for the
  // following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      full       <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
    end else begin
      if (accept) begin
        hold_left  <= in_left;
        hold_right <= in_right;
      end
      if (wrap) begin
        full <= accept;
      end else if (accept) begin
        full <= 1'b1;
      end
    end
  end

  // Shift words and registered line outputs for the upcoming cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_out     <= 1'b0;
      sd_out     <= 1'b0;
      underflow  <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
    end else if (!en) begin
      ws_out     <= 1'b0;
      sd_out     <= 1'b0;
      underflow  <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
    end else begin
      ws_out    <= ws_next;
      sd_out    <= 1'b0;
      underflow <= wrap && !full;
      if (wrap) begin
        left_word  <= full ? hold_left  : '0;
        right_word <= full ? hold_right : '0;
      end else if (data_slot) begin
        if (ws_next) begin
          sd_out     <= right_word[NUMBER_OF_BITS-1];
          right_word <= right_word << 1;
        end else begin
          sd_out    <= left_word[NUMBER_OF_BITS-1];
          left_word <= left_word << 1;
        end
      end
    end
  end

endmodule
